// File: rtl/onehot_req_encoder_if.sv
// Request/serve bundle for onehot_req_encoder: one-hot request capture on the
// input side, valid/ready binary index on the output side.
interface onehot_req_encoder_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
);
  logic         e;
  logic         in_valid;
  logic [N-1:0] y;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_s;
  logic [N-1:0] pend;
  logic         err;

  modport master (
    output e, in_valid, y, out_ready,
    input  in_ready, out_valid, out_s, pend, err
  );

  modport slave (
    input  e, in_valid, y, out_ready,
    output in_ready, out_valid, out_s, pend, err
  );
endinterface

// File: rtl/onehot_req_encoder.sv
// Captures one/multi-hot requests into a pending mask and serves them highest
// index first as binary indices. Define ONEHOT_REQ_CHECK_EN for the sticky err flag.
module onehot_req_encoder #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  onehot_req_encoder_if.slave bus
);

  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] set_mask_c, clr_mask_c;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_s_q, out_s_d;
  logic [W-1:0] top_c;
  logic         pop_c, load_c;

  // Highest set bit of the pending mask; later iterations override earlier ones.
  always_comb begin
    top_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pend_q[i]) top_c = W'(i);
    end
  end

  // Output stage reload and pending-mask update; a same-cycle set beats the clear.
  always_comb begin
    set_mask_c  = (bus.e && bus.in_valid) ? bus.y : '0;
    pop_c       = out_valid_q && bus.out_ready;
    load_c      = !out_valid_q || pop_c;
    clr_mask_c  = '0;
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    if (load_c) begin
      if (|pend_q) begin
        out_valid_d = 1'b1;
        out_s_d     = top_c;
        clr_mask_c  = N'(1) << top_c;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    pend_d = (pend_q & ~clr_mask_c) | set_mask_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
    end
  end

`ifdef ONEHOT_REQ_CHECK_EN
  logic err_q, err_d;
  logic y_onehot_c;

  // Flag any captured request word that is zero or has more than one bit set.
  always_comb begin
    y_onehot_c = (bus.y != '0) && ((bus.y & (bus.y - N'(1))) == '0);
    err_d      = err_q | (bus.e && bus.in_valid && !y_onehot_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = 1'b1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_s     = out_s_q;
  assign bus.pend      = pend_q;

endmodule

// File: tb/tb_onehot_req_encoder.sv
// Bench for onehot_req_encoder: directed cycle table followed by random traffic
// against a mask-arithmetic reference model.
module tb_onehot_req_encoder;
  localparam int unsigned N = 4;
  localparam int unsigned W = 2;
`ifdef ONEHOT_REQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  onehot_req_encoder_if #(.N(N), .W(W)) bus ();
  onehot_req_encoder #(.N(N), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic       rst_n;
    logic       e;
    logic       iv;
    logic [3:0] y;
    logic       ordy;
    logic [3:0] pend;
    logic       ov;
    logic [1:0] os;
    logic       errc;   // expected err when the checker is built
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_pend;
  int m_ov;
  int m_os;
  int m_err;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic iv,
                       input logic [3:0] y, input logic ordy);
    rst_n         = r;
    bus.e         = e;
    bus.in_valid  = iv;
    bus.y         = y;
    bus.out_ready = ordy;
  endtask

  // Spec rules applied to integer state: serve the highest pending index, then merge arrivals.
  task automatic model_step(input logic r, input logic e, input logic iv,
                            input int y, input logic ordy);
    int k;
    if (!r) begin
      m_pend = 0; m_ov = 0; m_os = 0; m_err = 0;
    end else begin
      if (m_ov == 0 || ordy) begin
        if (m_pend != 0) begin
          k      = $clog2(m_pend + 1) - 1;
          m_os   = k;
          m_ov   = 1;
          m_pend = m_pend - (1 << k);
        end else begin
          m_ov = 0;
        end
      end
      if (e && iv) begin
        m_pend = m_pend | y;
        if (CHK && $countones(y) != 1) m_err = 1;
      end
    end
  endtask

  vec_t tbl[30];

  initial begin
    // reset held two edges with requests present
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    // single request, two-cycle latency
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0};
    // priority with back-pressure
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, 4'b1011, 1'b0, 2'd2, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b1, 2'd3, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b1, 2'd3, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b1, 2'd3, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
    // set/clear collision on bit 1, served twice
    tbl[13] = '{1'b1, 1'b1, 1'b1, 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1};
    // enable gating
    tbl[17] = '{1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1};
    // multi-hot 0110: err (when built) sticky until reset, both indices served
    tbl[19] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 4'b0110, 1'b0, 2'd0, 1'b1};
    tbl[21] = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd2, 1'b1};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1};
    tbl[23] = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1};
    tbl[24] = '{1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    // legal one-hot leaves err clear; zero request word flags it
    tbl[25] = '{1'b1, 1'b1, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b0};
    tbl[26] = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b0};
    tbl[27] = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0};
    tbl[28] = '{1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1};
    tbl[29] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};

    drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].rst_n, tbl[i].e, tbl[i].iv, tbl[i].y, tbl[i].ordy);
      tick();
      chk($sformatf("row%0d pend", i), int'(bus.pend), int'(tbl[i].pend));
      chk($sformatf("row%0d out_valid", i), int'(bus.out_valid), int'(tbl[i].ov));
      chk($sformatf("row%0d out_s", i), int'(bus.out_s), int'(tbl[i].os));
      chk($sformatf("row%0d err", i), int'(bus.err), CHK ? int'(tbl[i].errc) : 0);
      if (i % 10 == 2) chk($sformatf("row%0d in_ready", i), int'(bus.in_ready), 1);
    end

    // Random traffic; the table ended in reset so the model starts cleared.
    m_pend = 0; m_ov = 0; m_os = 0; m_err = 0;
    for (int c = 0; c < 2000; c++) begin
      logic       r, e, iv, ordy;
      logic [3:0] y;
      r    = ($urandom_range(0, 59) != 0);
      e    = ($urandom_range(0, 7) != 0);
      iv   = ($urandom_range(0, 2) == 0);
      y    = ($urandom_range(0, 1) == 0) ? 4'(1 << $urandom_range(0, 3))
                                         : 4'($urandom_range(0, 15));
      ordy = ($urandom_range(0, 3) != 0);
      drive(r, e, iv, y, ordy);
      model_step(r, e, iv, int'(y), ordy);
      tick();
      chk($sformatf("rnd%0d pend", c), int'(bus.pend), m_pend);
      chk($sformatf("rnd%0d out_valid", c), int'(bus.out_valid), m_ov);
      chk($sformatf("rnd%0d out_s", c), int'(bus.out_s), m_os);
      chk($sformatf("rnd%0d err", c), int'(bus.err), m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
